// File: rtl/adau_cfg_sequencer.sv
// adau_cfg_sequencer: power-up configuration sequencer for the ADAU codec.
//
// After reset it waits POWERUP_WAIT clk cycles. It then writes NUM_REGS table entries over a
// write-only I2C master. Each entry is sent as {DEV_ADDR,W}, reg_addr[15:8], reg_addr[7:0],
// data, MSB first, framed by START/STOP and followed by a bus-free gap. init_done is raised
// once every entry has been ACKed; init_error is raised on an unrecoverable NACK.
//
// Build option: define ADAU_CFG_RETRY_EN to re-send a NACKed entry up to 3 times before
// giving up. Without it the first NACK is fatal.
//
// Table: ROM_INIT packs NUM_REGS 24-bit words {reg_addr[15:0], data[7:0]}, entry i in bits
// [24*i +: 24]. This is normally generated from adau_cfg.mem at build time.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   scl_t       SCL tristate (1 = released, 0 = drive low)
//   sda_t       SDA tristate (1 = released, 0 = drive low)
//   sda_i       SDA pin readback, used for ACK sampling
//   busy        high from the end of the power-up wait until DONE or ERROR
//   init_done   sticky, every entry ACKed
//   init_error  sticky, codec stopped acknowledging
//   entry_idx   current or last table entry, for debug
module adau_cfg_sequencer #(
    parameter logic [6:0]             DEV_ADDR     = 7'h38,
    parameter int unsigned            CLK_DIV      = 62,
    parameter int unsigned            POWERUP_WAIT = 1_000_000,
    parameter int unsigned            NUM_REGS     = 16,
    parameter logic [24*NUM_REGS-1:0] ROM_INIT     = '0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       scl_t,
    output logic       sda_t,
    input  logic       sda_i,
    output logic       busy,
    output logic       init_done,
    output logic       init_error,
    output logic [7:0] entry_idx
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        StWait,
        StStart,
        StByte,
        StAck,
        StStop,
        StGap,
        StNext,
`ifdef ADAU_CFG_RETRY_EN
        StRetry,
`endif
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [31:0]       wait_q, wait_d;
    logic [1:0]        q_q, q_d;        // quarter within the current bit/phase
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [7:0]        idx_q, idx_d;
    logic              nack_q, nack_d;  // ACK sample taken at the end of q2
    logic              fail_q, fail_d;  // current attempt was NACKed, STOP is in flight
    logic              scl_q, scl_d;
    logic              sda_q, sda_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              tick;
    logic [23:0]       entry_word;
    logic [7:0]        cur_byte;
    logic              cur_bit;
`ifdef ADAU_CFG_RETRY_EN
    logic [1:0]        retry_q, retry_d;
`endif

    // Free-running quarter-bit divider; it is never re-aligned to the state machine.
    assign tick  = (div_q == DivW'(CLK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        q_d     = q_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        nack_d  = nack_q;
        fail_d  = fail_q;
`ifdef ADAU_CFG_RETRY_EN
        retry_d = retry_q;
`endif
        unique case (state_q)
            StWait: begin
                wait_d = wait_q + 32'd1;
                if (wait_q == POWERUP_WAIT - 1) state_d = StStart;
            end
            StStart: begin
                if (tick) begin
                    q_d = q_q + 2'd1;
                    if (q_q == 2'd3) begin
                        state_d = StByte;
                        bit_d   = '0;
                        byte_d  = '0;
                        nack_d  = 1'b0;
                        fail_d  = 1'b0;
                    end
                end
            end
            StByte: begin
                if (tick) begin
                    q_d = q_q + 2'd1;
                    if (q_q == 2'd3) begin
                        if (bit_q == 3'd7) state_d = StAck;
                        else bit_d = bit_q + 3'd1;
                    end
                end
            end
            StAck: begin
                if (tick) begin
                    q_d = q_q + 2'd1;
                    if (q_q == 2'd2) nack_d = sda_i;
                    if (q_q == 2'd3) begin
                        bit_d = '0;
                        if (nack_q) begin
                            fail_d  = 1'b1;
                            state_d = StStop;
                        end else if (byte_q == 2'd3) begin
                            state_d = StStop;
                        end else begin
                            byte_d  = byte_q + 2'd1;
                            state_d = StByte;
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    q_d = q_q + 2'd1;
                    if (q_q == 2'd3) begin
                        if (!fail_q) state_d = StGap;
`ifdef ADAU_CFG_RETRY_EN
                        else if (retry_q == 2'd3) state_d = StError;
                        else state_d = StRetry;
`else
                        else state_d = StError;
`endif
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    q_d = q_q + 2'd1;
                    if (q_q == 2'd3) state_d = StNext;
                end
            end
            StNext: begin
                q_d = '0;
`ifdef ADAU_CFG_RETRY_EN
                retry_d = '0;
`endif
                if (idx_q == 8'(NUM_REGS - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StStart;
                end
            end
`ifdef ADAU_CFG_RETRY_EN
            StRetry: begin
                q_d     = '0;
                retry_d = retry_q + 2'd1;
                state_d = StStart;
            end
`endif
            default: ;  // StDone / StError hold until reset
        endcase
    end

    // Byte being shifted in the next cycle, taken from next-state so the registered
    // line outputs line up with the registered state.
    always_comb begin
        entry_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx_d == 8'(i)) entry_word = ROM_INIT[24*i +: 24];
        end
        case (byte_d)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = entry_word[23:16];
            2'd2:    cur_byte = entry_word[15:8];
            default: cur_byte = entry_word[7:0];
        endcase
        cur_bit = cur_byte[3'd7 - bit_d];
    end

    // Line levels are decoded from next-state and registered so the pins never glitch.
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        unique case (state_d)
            StStart: begin
                sda_d = (q_d == 2'd0);
                scl_d = (q_d <= 2'd1);
            end
            StByte: begin
                scl_d = (q_d == 2'd1) || (q_d == 2'd2);
                sda_d = cur_bit;
            end
            StAck: begin
                scl_d = (q_d == 2'd1) || (q_d == 2'd2);
            end
            StStop: begin
                scl_d = (q_d != 2'd0);
                sda_d = (q_d >= 2'd2);
            end
            default: ;
        endcase
        busy_d  = (state_d != StWait) && (state_d != StDone) && (state_d != StError);
        done_d  = (state_d == StDone);
        error_d = (state_d == StError);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StWait;
            div_q   <= '0;
            wait_q  <= '0;
            q_q     <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            nack_q  <= 1'b0;
            fail_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            wait_q  <= wait_d;
            q_q     <= q_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            nack_q  <= nack_d;
            fail_q  <= fail_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

`ifdef ADAU_CFG_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retry_q <= '0;
        else     retry_q <= retry_d;
    end
`endif

    assign scl_t      = scl_q;
    assign sda_t      = sda_q;
    assign busy       = busy_q;
    assign init_done  = done_q;
    assign init_error = error_q;
    assign entry_idx  = idx_q;

endmodule

// File: tb/tb_adau_cfg_sequencer.sv
// Bench for adau_cfg_sequencer: a bus monitor/codec model decodes START, bytes and STOP into
// an observed-event queue; each directed step pushes its expected events and compares them.
module tb_adau_cfg_sequencer;

    localparam int unsigned CD = 2;
    localparam int unsigned PW = 10;
    localparam int unsigned NR = 3;
    localparam int START_EV = 256;
    localparam int STOP_EV  = 512;
    localparam logic [71:0] TBL = {24'h40F255, 24'h40150A, 24'h400001};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_t, sda_t, busy, init_done, init_error;
    logic [7:0] entry_idx;
    logic       codec_low = 1'b0;
    logic       sda_bus;

    assign sda_bus = sda_t & ~codec_low;

    adau_cfg_sequencer #(
        .DEV_ADDR    (7'h38),
        .CLK_DIV     (CD),
        .POWERUP_WAIT(PW),
        .NUM_REGS    (NR),
        .ROM_INIT    (TBL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_t     (scl_t),
        .sda_t     (sda_t),
        .sda_i     (sda_bus),
        .busy      (busy),
        .init_done (init_done),
        .init_error(init_error),
        .entry_idx (entry_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int obs_q[$];
    int exp_q[$];
    int mode = 0;  // 0: ACK all, 1: NACK entry 1 address twice, 2: NACK everything
    logic [23:0] tbl [3];

    // Bus monitor plus codec model.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, scl_s, sda_s;
    logic [7:0] shreg = '0;
    int         bitcnt = 0, byte_no = 0, entries_done = 0, nack_cnt = 0, glitches = 0;
    logic       ack_phase = 1'b0, first_fall_seen = 1'b0, first_fall_scl = 1'b0;
    logic       give_ack;

    always @(negedge clk) begin
        if (rst) begin
            prev_scl = 1'b1; prev_sda = 1'b1; bitcnt = 0; byte_no = 0; ack_phase = 1'b0;
            entries_done = 0; nack_cnt = 0; codec_low = 1'b0;
        end else begin
            scl_s = scl_t;
            sda_s = sda_bus;
            if (scl_s != prev_scl && sda_s != prev_sda) glitches++;
            if (!first_fall_seen && prev_sda && !sda_s) begin
                first_fall_seen = 1'b1;
                first_fall_scl  = prev_scl & scl_s;
            end
            if (prev_scl && scl_s && prev_sda && !sda_s) begin
                obs_q.push_back(START_EV);
                bitcnt = 0; byte_no = 0; ack_phase = 1'b0;
            end else if (prev_scl && scl_s && !prev_sda && sda_s) begin
                obs_q.push_back(STOP_EV);
                if (byte_no == 4) entries_done++;
            end else if (!prev_scl && scl_s) begin
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], sda_s};
                    bitcnt++;
                    if (bitcnt == 8) obs_q.push_back(int'(shreg));
                end
            end else if (prev_scl && !scl_s) begin
                if (ack_phase) begin
                    ack_phase = 1'b0; codec_low = 1'b0; bitcnt = 0; byte_no++;
                end else if (bitcnt == 8) begin
                    ack_phase = 1'b1;
                    if (mode == 2) give_ack = 1'b0;
                    else if (mode == 1 && entries_done == 1 && byte_no == 0 && nack_cnt < 2) begin
                        give_ack = 1'b0;
                        nack_cnt++;
                    end else give_ack = 1'b1;
                    codec_low = give_ack;
                end
            end
            prev_scl = scl_s;
            prev_sda = sda_s;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_entry(input int e);
        exp_q.push_back(START_EV);
        exp_q.push_back(8'h70);
        exp_q.push_back(int'(tbl[e][23:16]));
        exp_q.push_back(int'(tbl[e][15:8]));
        exp_q.push_back(int'(tbl[e][7:0]));
        exp_q.push_back(STOP_EV);
    endtask

    task automatic push_nacked();
        exp_q.push_back(START_EV);
        exp_q.push_back(8'h70);
        exp_q.push_back(STOP_EV);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_event_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic count_starts(output int n);
        n = 0;
        foreach (obs_q[i]) if (obs_q[i] == START_EV) n++;
    endtask

    task automatic apply_rst();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic release_rst(output int t);
        @(negedge clk);
        rst = 1'b0;
        t = 0;
        while (!busy && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic run_to_end(inout int t, input int budget);
        int t0;
        t0 = t;
        while (!(init_done || init_error) && (t - t0) < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("end_reached", 32'(init_done | init_error), 1);
    endtask

    initial begin
        int t, n;
        tbl[0] = 24'h400001;
        tbl[1] = 24'h40150A;
        tbl[2] = 24'h40F255;

        // Reset state, power-up wait, full table with byte content and completion time.
        mode = 0;
        apply_rst();
        check("rst_scl_t", scl_t, 1);
        check("rst_sda_t", sda_t, 1);
        check("rst_busy", busy, 0);
        check("rst_done", init_done, 0);
        check("rst_error", init_error, 0);
        check("rst_entry_idx", entry_idx, 0);
        for (int e = 0; e < 3; e++) push_entry(e);
        release_rst(t);
        check("busy_rise_cycles", t, 10);
        run_to_end(t, 3000);
        check("done_time_window", 32'(t >= 944 && t <= 948), 1);
        check("full_done", init_done, 1);
        check("full_error", init_error, 0);
        check("full_busy", busy, 0);
        check("full_entry_idx", entry_idx, 2);
        check("full_lines_released", {scl_t, sda_t}, 2'b11);
        check("first_sda_fall_seen", first_fall_seen, 1);
        check("first_sda_fall_scl_high", first_fall_scl, 1);
        compare_events("full");

        // Entry 1 address NACKed twice.
        mode = 1;
        apply_rst();
        push_entry(0);
`ifdef ADAU_CFG_RETRY_EN
        push_nacked();
        push_nacked();
        push_entry(1);
        push_entry(2);
`else
        push_nacked();
`endif
        release_rst(t);
        run_to_end(t, 3000);
        count_starts(n);
`ifdef ADAU_CFG_RETRY_EN
        check("retry_start_count", n, 5);
        check("retry_done", init_done, 1);
        check("retry_error", init_error, 0);
        check("retry_entry_idx", entry_idx, 2);
`else
        check("nack1_start_count", n, 2);
        check("nack1_done", init_done, 0);
        check("nack1_error", init_error, 1);
        check("nack1_entry_idx", entry_idx, 1);
`endif
        compare_events("retry");

        // Codec never ACKs.
        mode = 2;
        apply_rst();
`ifdef ADAU_CFG_RETRY_EN
        for (int i = 0; i < 4; i++) push_nacked();
`else
        push_nacked();
`endif
        release_rst(t);
        run_to_end(t, 3000);
        repeat (20) @(posedge clk);
        #1;
        check("err_error", init_error, 1);
        check("err_done", init_done, 0);
        check("err_busy", busy, 0);
        check("err_entry_idx", entry_idx, 0);
        check("err_lines_released", {scl_t, sda_t}, 2'b11);
        compare_events("err");

        // Reset in the middle of entry 1's data byte.
        mode = 0;
        apply_rst();
        release_rst(t);
        n = 0;
        while (entry_idx != 8'd1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_reach_entry1", entry_idx, 1);
        repeat (260) @(posedge clk);
        n = 0;
        @(negedge clk);
        while (scl_t && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_scl_low_before_rst", scl_t, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_scl_released", scl_t, 1);
        check("mid_rst_sda_released", sda_t, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_entry_idx", entry_idx, 0);
        repeat (4) @(posedge clk);
        #1;
        obs_q.delete();
        exp_q.delete();
        for (int e = 0; e < 3; e++) push_entry(e);
        release_rst(t);
        check("mid_busy_rise_cycles", t, 10);
        run_to_end(t, 3000);
        check("mid_done", init_done, 1);
        check("mid_error", init_error, 0);
        check("mid_entry_idx", entry_idx, 2);
        compare_events("mid");

        check("no_simultaneous_line_changes", glitches, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
